c_sum_sequencer: RTL and testbench

Frame-level controller for the 32-lane C adder-tree datapath. It accepts a programmable number of 32-lane {C1,C0} words over a valid/ready stream and reduces each word to a signed lane sum. It accumulates the lane sums into one wide signed frame total and returns that total over a valid/ready result port. It sits between the clause-state scan logic and the scoring/decision logic.

---
 rtl/c_sum_sequencer_if.sv | 27 ++
 rtl/c_sum_sequencer.sv | 161 ++++++++++++++++
 tb/tb_c_sum_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/c_sum_sequencer_if.sv
// Stream/result bundle for c_sum_sequencer: frame start, word input stream,
// and frame-total result handshake. The slave side is the sequencer itself.
interface c_sum_sequencer_if #(
  parameter int LEN_W = 5,
  parameter int ACC_W = 11
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             inValid;
  logic             inReady;
  logic [31:0]      c0;
  logic [31:0]      c1;
  logic             outValid;
  logic             outReady;
  logic [ACC_W-1:0] sumOut;
  logic             busy;

  modport master (
    output start, len, inValid, c0, c1, outReady,
    input  inReady, outValid, sumOut, busy
  );

  modport slave (
    input  start, len, inValid, c0, c1, outReady,
    output inReady, outValid, sumOut, busy
  );
endinterface

// File: rtl/c_sum_sequencer.sv
// Frame controller for the 32-lane C adder tree: reduces each {C1,C0} word to a
// signed lane sum and accumulates a frame total. Optional macro C_SEQ_PIPE_EN
// inserts a word-sum register and a DRAIN state before the result is offered.
module c_sum_sequencer #(
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = 5,
  parameter int ACC_W     = 11
) (
  input logic              i_clk,
  input logic              i_rst_n,
  c_sum_sequencer_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  state_t                  r_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_beatCnt;
  logic signed [ACC_W-1:0] r_accum;
  logic                    r_inReady;
  logic                    r_outValid;
  logic                    r_busy;
`ifdef C_SEQ_PIPE_EN
  logic signed [6:0]       r_wordSum;
  logic                    r_sumValid;
`endif

  logic signed [6:0] w_lvl0 [32];
  logic signed [6:0] w_lvl1 [16];
  logic signed [6:0] w_lvl2 [8];
  logic signed [6:0] w_lvl3 [4];
  logic signed [6:0] w_lvl4 [2];
  logic signed [6:0] w_wordSum;
  logic [LEN_W-1:0]  w_lenClamped;
  logic              w_accept;
  logic              w_lastBeat;

  // Each lane {C1,C0} is a signed 2-bit value; sign-extend before the tree.
  for (genvar gi = 0; gi < 32; gi++) begin : g_lane
    assign w_lvl0[gi] = 7'($signed({io.c1[gi], io.c0[gi]}));
  end
  for (genvar gi = 0; gi < 16; gi++) begin : g_lvl1
    assign w_lvl1[gi] = w_lvl0[2*gi] + w_lvl0[2*gi+1];
  end
  for (genvar gi = 0; gi < 8; gi++) begin : g_lvl2
    assign w_lvl2[gi] = w_lvl1[2*gi] + w_lvl1[2*gi+1];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_lvl3
    assign w_lvl3[gi] = w_lvl2[2*gi] + w_lvl2[2*gi+1];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_lvl4
    assign w_lvl4[gi] = w_lvl3[2*gi] + w_lvl3[2*gi+1];
  end
  assign w_wordSum = w_lvl4[0] + w_lvl4[1];

  assign w_lenClamped = (io.len > MAX_LEN) ? MAX_LEN : io.len;
  assign w_accept     = io.inValid & r_inReady;
  assign w_lastBeat   = (r_beatCnt + LEN_W'(1)) == r_len;

  // S_DRAIN is only ever entered when the word-sum register exists.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_beatCnt  <= '0;
      r_accum    <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef C_SEQ_PIPE_EN
      r_wordSum  <= '0;
      r_sumValid <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.start) begin
            r_len     <= w_lenClamped;
            r_beatCnt <= '0;
            r_accum   <= '0;
            r_busy    <= 1'b1;
            if (w_lenClamped == '0) begin
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
            end else begin
              r_state   <= S_ACCUM;
              r_inReady <= 1'b1;
            end
          end
        end

        S_ACCUM: begin
`ifdef C_SEQ_PIPE_EN
          r_sumValid <= w_accept;
          if (w_accept) begin
            r_wordSum <= w_wordSum;
          end
          if (r_sumValid) begin
            r_accum <= r_accum + ACC_W'(r_wordSum);
          end
`else
          if (w_accept) begin
            r_accum <= r_accum + ACC_W'(w_wordSum);
          end
`endif
          if (w_accept) begin
            r_beatCnt <= r_beatCnt + LEN_W'(1);
            if (w_lastBeat) begin
              r_inReady <= 1'b0;
`ifdef C_SEQ_PIPE_EN
              r_state   <= S_DRAIN;
`else
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
`endif
            end
          end
        end

`ifdef C_SEQ_PIPE_EN
        S_DRAIN: begin
          if (r_sumValid) begin
            r_accum <= r_accum + ACC_W'(r_wordSum);
          end
          r_sumValid <= 1'b0;
          r_state    <= S_DONE;
          r_outValid <= 1'b1;
        end
`endif

        S_DONE: begin
          if (io.outReady) begin
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_inReady  <= 1'b0;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign io.inReady  = r_inReady;
  assign io.outValid = r_outValid;
  assign io.busy     = r_busy;
  assign io.sumOut   = r_accum;

endmodule

// File: tb/tb_c_sum_sequencer.sv
// Self-checking bench for c_sum_sequencer: directed frames plus randomized frames
// scored against a lane-count model of the frame total.
module tb_c_sum_sequencer;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = 5;
  localparam int ACC_W     = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  logic [31:0] c0Arr [32];
  logic [31:0] c1Arr [32];

  c_sum_sequencer_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) busIf ();

  c_sum_sequencer #(
    .MAX_BEATS(MAX_BEATS),
    .LEN_W(LEN_W),
    .ACC_W(ACC_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .io(busIf.slave)
  );

  always #5 clk = ~clk;

  // A word is worth (number of set C0 bits) minus twice (number of set C1 bits).
  function automatic int wordValue(input logic [31:0] c0, input logic [31:0] c1);
    return $countones(c0) - 2 * $countones(c1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // validMode: 0 = always valid, 1 = toggle 1,0,1,0..., 2 = random gaps.
  task automatic applyStimulus(input string tag, input int lenReq, input int validMode,
                               input int readyDelay);
    int effLen, expSum, accepted, budget;
    logic v;
    logic [ACC_W-1:0] expBits;
    effLen = (lenReq > MAX_BEATS) ? MAX_BEATS : lenReq;
    expSum = 0;
    for (int k = 0; k < effLen; k++) expSum += wordValue(c0Arr[k], c1Arr[k]);
    expBits = expSum[ACC_W-1:0];

    @(negedge clk);
    checkOutput({tag, "_idleBusy"}, 64'(busIf.busy), 64'(0));
    busIf.start = 1'b1;
    busIf.len   = lenReq[LEN_W-1:0];
    @(negedge clk);
    busIf.start = 1'b0;
    busIf.len   = LEN_W'($urandom);
    checkOutput({tag, "_busy"}, 64'(busIf.busy), 64'(1));

    if (effLen == 0) begin
      checkOutput({tag, "_zeroValid"}, 64'(busIf.outValid), 64'(1));
      checkOutput({tag, "_zeroReady"}, 64'(busIf.inReady), 64'(0));
    end else begin
      checkOutput({tag, "_readyAfterStart"}, 64'(busIf.inReady), 64'(1));
      accepted = 0;
      budget   = 0;
      while (accepted < effLen && budget < 400) begin
        case (validMode)
          0:       v = 1'b1;
          1:       v = (budget % 2) == 0;
          default: v = $urandom_range(0, 3) != 0;
        endcase
        if (v) begin
          busIf.c0 = c0Arr[accepted];
          busIf.c1 = c1Arr[accepted];
        end else begin
          busIf.c0 = $urandom;
          busIf.c1 = $urandom;
        end
        busIf.inValid = v;
        if (v && busIf.inReady) accepted++;
        @(negedge clk);
        budget++;
      end
      checkOutput({tag, "_accepted"}, 64'(accepted), 64'(effLen));
      busIf.inValid = 1'b1;
      busIf.c0      = $urandom;
      busIf.c1      = $urandom;
      checkOutput({tag, "_readyLow"}, 64'(busIf.inReady), 64'(0));
`ifdef C_SEQ_PIPE_EN
      checkOutput({tag, "_drainValid"}, 64'(busIf.outValid), 64'(0));
      @(negedge clk);
      checkOutput({tag, "_drainReadyLow"}, 64'(busIf.inReady), 64'(0));
`endif
      checkOutput({tag, "_outValid"}, 64'(busIf.outValid), 64'(1));
      busIf.inValid = 1'b0;
    end

    for (int i = 0; i < readyDelay; i++) begin
      busIf.outReady = 1'b0;
      busIf.start    = 1'($urandom_range(0, 1));
      busIf.len      = LEN_W'($urandom_range(1, 4));
      checkOutput({tag, "_sumHold"}, 64'(busIf.sumOut), 64'(expBits));
      checkOutput({tag, "_validHold"}, 64'(busIf.outValid), 64'(1));
      @(negedge clk);
    end
    checkOutput({tag, "_sum"}, 64'(busIf.sumOut), 64'(expBits));
    busIf.outReady = 1'b1;
    busIf.start    = 1'b1;
    busIf.len      = LEN_W'(3);
    @(negedge clk);
    busIf.outReady = 1'b0;
    busIf.start    = 1'b0;
    checkOutput({tag, "_idleValid"}, 64'(busIf.outValid), 64'(0));
    checkOutput({tag, "_idleReady"}, 64'(busIf.inReady), 64'(0));
    checkOutput({tag, "_idleBusyEnd"}, 64'(busIf.busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIf.start    = 1'b0;
    busIf.len      = '0;
    busIf.inValid  = 1'b0;
    busIf.c0       = '0;
    busIf.c1       = '0;
    busIf.outReady = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_inReady", 64'(busIf.inReady), 64'(0));
    checkOutput("rst_outValid", 64'(busIf.outValid), 64'(0));
    checkOutput("rst_busy", 64'(busIf.busy), 64'(0));
    checkOutput("rst_sum", 64'(busIf.sumOut), 64'(0));
    rst_n = 1'b1;

    c0Arr[0] = 32'hFFFF_FFFF; c1Arr[0] = 32'h0;
    applyStimulus("len1Pos", 1, 0, 0);

    for (int k = 0; k < 16; k++) begin
      c0Arr[k] = 32'h0; c1Arr[k] = 32'hFFFF_FFFF;
    end
    applyStimulus("len16Neg", 16, 0, 0);

    c0Arr[0] = 32'hFFFF_FFFF; c1Arr[0] = 32'h0;
    c0Arr[1] = 32'hFFFF_FFFF; c1Arr[1] = 32'hFFFF_FFFF;
    c0Arr[2] = 32'h0;         c1Arr[2] = 32'h0;
    c0Arr[3] = 32'h0000_001F; c1Arr[3] = 32'h0;
    applyStimulus("toggle", 4, 1, 0);

    for (int k = 0; k < 32; k++) begin
      c0Arr[k] = $urandom; c1Arr[k] = $urandom;
    end
    applyStimulus("backpressure", 3, 0, 5);
    applyStimulus("len0", 0, 0, 2);
    applyStimulus("len20", 20, 2, 1);

    for (int k = 0; k < 8; k++) begin
      c0Arr[k] = $urandom; c1Arr[k] = $urandom;
    end
    @(negedge clk);
    busIf.start = 1'b1;
    busIf.len   = LEN_W'(8);
    @(negedge clk);
    busIf.start   = 1'b0;
    busIf.inValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      busIf.c0 = c0Arr[k];
      busIf.c1 = c1Arr[k];
      @(negedge clk);
    end
    busIf.inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst_inReady", 64'(busIf.inReady), 64'(0));
    checkOutput("midRst_outValid", 64'(busIf.outValid), 64'(0));
    checkOutput("midRst_busy", 64'(busIf.busy), 64'(0));
    checkOutput("midRst_sum", 64'(busIf.sumOut), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    c0Arr[0] = 32'h1; c1Arr[0] = 32'h0;
    c0Arr[1] = 32'h1; c1Arr[1] = 32'h0;
    applyStimulus("afterRst", 2, 0, 0);

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 32; k++) begin
        c0Arr[k] = $urandom; c1Arr[k] = $urandom;
      end
      applyStimulus("rand", int'($urandom_range(0, 20)), 2, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
